// File: rtl/mul_share_pkg.sv
// Shared constants, FSM encoding and index helper for the multiplier-sharing controller.
package mul_share_pkg;

  localparam int OP_W   = 32;
  localparam int PROD_W = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Modulo-n increment; n is small and idx is always below n.
  function automatic int wrap_inc(input int idx, input int n);
    int nxt;
    nxt = idx + 1;
    if (nxt >= n) begin
      nxt = 0;
    end else begin
      nxt = idx + 1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mul32bit.sv
// Existing 32x32 signed combinational multiplier shared by the controller.
module mul32bit (
  input  logic signed [31:0] a,
  input  logic signed [31:0] b,
  output logic signed [63:0] p
);

  assign p = a * b;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_arbiter
  import mul_share_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int cand;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = int'(ptr);
    for (int k = 0; k < N; k++) begin
      if (!any && req[cand]) begin
        any  = 1'b1;
        idx  = IDX_W'(cand);
        cand = wrap_inc(cand, N);
      end else begin
        cand = wrap_inc(cand, N);
      end
    end
    gnt[idx] = any;
  end

endmodule

// File: rtl/mul32_share_ctrl.sv
// Time-shares one mul32bit among N_REQ requesters: round-robin grant, registered
// operands, registered product, single valid/ready response port.
module mul32_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*32-1:0]   req_a,
  input  logic [N_REQ*32-1:0]   req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [63:0]           rsp_p
);

  state_e                    state_q, state_d;
  logic [ID_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic signed [OP_W-1:0]    op_a_q, op_a_d;
  logic signed [OP_W-1:0]    op_b_q, op_b_d;
  logic [ID_W-1:0]           op_id_q, op_id_d;
  logic signed [PROD_W-1:0]  rsp_p_q, rsp_p_d;
  logic [ID_W-1:0]           rsp_id_q, rsp_id_d;
  logic                      rsp_valid_q, rsp_valid_d;

  logic [N_REQ-1:0]          arb_gnt;
  logic [ID_W-1:0]           arb_idx;
  logic                      arb_any;
  logic                      grant_en;
  logic                      grant_fire;
  logic signed [OP_W-1:0]    sel_a, sel_b;
  logic signed [PROD_W-1:0]  mul_p;

  rr_arbiter #(
    .N     (N_REQ),
    .IDX_W (ID_W)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  mul32bit u_mul (
    .a (op_a_q),
    .b (op_b_q),
    .p (mul_p)
  );

  // Grants are possible in IDLE, or in DONE while the current result is being taken.
  always_comb begin
    grant_en = 1'b0;
    case (state_q)
      S_IDLE:  grant_en = 1'b1;
      S_DONE:  grant_en = rsp_ready;
      default: grant_en = 1'b0;
    endcase
    grant_fire = grant_en & arb_any;
    if (grant_en && !rst) begin
      req_ready = arb_gnt;
    end else begin
      req_ready = '0;
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_a = (arb_idx == ID_W'(i)) ? req_a[i*OP_W +: OP_W] : sel_a;
      sel_b = (arb_idx == ID_W'(i)) ? req_b[i*OP_W +: OP_W] : sel_b;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_id_d     = op_id_q;
    rsp_p_d     = rsp_p_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;

    if (grant_fire) begin
      op_a_d   = sel_a;
      op_b_d   = sel_b;
      op_id_d  = arb_idx;
      rr_ptr_d = ID_W'(wrap_inc(int'(arb_idx), N_REQ));
    end else begin
      rr_ptr_d = rr_ptr_q;
    end

    case (state_q)
      S_IDLE: begin
        if (grant_fire) begin
          state_d = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        rsp_p_d     = mul_p;
        rsp_id_d    = op_id_q;
        rsp_valid_d = 1'b1;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (grant_fire) begin
            state_d = S_CALC;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_DONE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_id_q     <= '0;
      rsp_p_q     <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_id_q     <= op_id_d;
      rsp_p_q     <= rsp_p_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = rsp_p_q;

endmodule

// File: tb/tb_mul32_share_ctrl.sv
// Bench for mul32_share_ctrl: transaction-level model checked every cycle plus
// directed scenarios with hand-computed results.
module tb_mul32_share_ctrl;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*32-1:0] req_a;
  logic [N_REQ*32-1:0] req_b;
  logic [N_REQ-1:0]    req_ready;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [ID_W-1:0]     rsp_id;
  logic [63:0]         rsp_p;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_win = -1;
  logic [N_REQ-1:0] keep;

  // Model: one multiply in flight, one result slot, rotating priority pointer.
  int                 m_ptr = 0;
  bit                 m_busy = 1'b0;
  bit                 m_slot = 1'b0;
  int                 m_busy_id = 0;
  int                 m_slot_id = 0;
  logic signed [63:0] m_busy_p = '0;
  logic signed [63:0] m_slot_p = '0;
  logic signed [31:0] ta, tbv;
  int                 g_log[$];
  int                 g_cyc[$];
  int                 exp_order[5] = '{0, 1, 2, 3, 0};

  always #5 clk = ~clk;

  mul32_share_ctrl #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [N_REQ-1:0] exp_rdy;
    int win;
    int c;
    cyc++;
    if (rst) begin
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_p", rsp_p, 64'd0);
      check("rst_rsp_id", 64'(rsp_id), 64'd0);
      m_ptr = 0; m_busy = 1'b0; m_slot = 1'b0;
      m_slot_id = 0; m_slot_p = '0;
      last_win = -1;
    end else begin
      win = -1;
      if (!m_busy && (!m_slot || rsp_ready)) begin
        for (int k = 0; k < N_REQ; k++) begin
          c = (m_ptr + k) % N_REQ;
          if (win < 0 && req_valid[c]) win = c;
        end
      end
      exp_rdy = '0;
      if (win >= 0) exp_rdy[win] = 1'b1;
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      check("rsp_valid", 64'(rsp_valid), 64'(m_slot));
      check("rsp_id", 64'(rsp_id), 64'(m_slot_id));
      check("rsp_p", rsp_p, m_slot_p);
      if (m_slot && rsp_ready) m_slot = 1'b0;
      if (m_busy) begin
        m_slot = 1'b1; m_slot_id = m_busy_id; m_slot_p = m_busy_p; m_busy = 1'b0;
      end
      if (win >= 0) begin
        ta = req_a[win*32 +: 32];
        tbv = req_b[win*32 +: 32];
        m_busy = 1'b1; m_busy_id = win; m_busy_p = ta * tbv;
        m_ptr = (win + 1) % N_REQ;
        g_log.push_back(win);
        g_cyc.push_back(cyc);
      end
      last_win = win;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  task automatic tick(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      if (last_win >= 0 && !keep[last_win]) req_valid[last_win] = 1'b0;
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_valid[i] = 1'b1;
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1; keep = '0;
    tick(2);
    check("reset_valid", 64'(rsp_valid), 64'd0);
    check("reset_p", rsp_p, 64'd0);
    rst = 1'b0;
    tick(1);

    // Single request, two-cycle latency
    set_req(0, 32'd8, 32'd125);
    #1;
    check("single_ready", 64'(req_ready), 64'h1);
    tick(1);
    check("single_calc_valid", 64'(rsp_valid), 64'd0);
    tick(1);
    check("single_valid", 64'(rsp_valid), 64'd1);
    check("single_id", 64'(rsp_id), 64'd0);
    check("single_p", rsp_p, 64'd1000);
    tick(1);

    // Signed products, issued back-to-back
    set_req(1, 32'hFFFF_FFFD, 32'd7);
    tick(2);
    check("neg_p", rsp_p, 64'hFFFF_FFFF_FFFF_FFEB);
    check("neg_id", 64'(rsp_id), 64'd1);
    set_req(2, 32'h8000_0000, 32'h8000_0000);
    tick(2);
    check("min_p", rsp_p, 64'h4000_0000_0000_0000);
    check("min_id", 64'(rsp_id), 64'd2);
    set_req(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick(2);
    check("m1_p", rsp_p, 64'd1);
    check("m1_id", 64'(rsp_id), 64'd3);
    tick(1);

    // Fairness with all requesters always valid
    g_log.delete(); g_cyc.delete();
    keep = 4'hF;
    for (int i = 0; i < N_REQ; i++) set_req(i, 32'(i + 2), 32'(10 * (i + 1)));
    tick(9);
    req_valid = '0; keep = '0;
    tick(3);
    check("rr_count", 64'(g_log.size()), 64'd5);
    for (int k = 0; k < g_log.size() && k < 5; k++) check("rr_order", 64'(g_log[k]), 64'(exp_order[k]));
    for (int k = 0; k + 1 < g_cyc.size(); k++) check("rr_gap", 64'(g_cyc[k+1] - g_cyc[k]), 64'd2);

    // Backpressure, then release into a wrapped grant
    rsp_ready = 1'b0;
    set_req(2, 32'd225, 32'd30);
    tick(2);
    set_req(1, 32'd11, 32'hFFFF_FFFC);
    set_req(3, 32'd6, 32'd7);
    for (int s = 0; s < 5; s++) begin
      #1;
      check("stall_valid", 64'(rsp_valid), 64'd1);
      check("stall_p", rsp_p, 64'd6750);
      check("stall_id", 64'(rsp_id), 64'd2);
      check("stall_ready", 64'(req_ready), 64'd0);
      tick(1);
    end
    rsp_ready = 1'b1;
    #1;
    check("release_ready", 64'(req_ready), 64'h8);
    tick(2);
    #1;
    check("wrap_p", rsp_p, 64'd42);
    check("wrap_id", 64'(rsp_id), 64'd3);
    check("wrap_next_ready", 64'(req_ready), 64'h2);
    tick(2);
    check("wrap2_p", rsp_p, 64'hFFFF_FFFF_FFFF_FFD4);
    check("wrap2_id", 64'(rsp_id), 64'd1);
    tick(1);

    // Reset while in CALC
    set_req(1, 32'd1000, 32'd1000);
    tick(1);
    set_req(0, 32'd12, 32'hFFFF_FFF4);
    set_req(2, 32'd5, 32'd5);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(rsp_valid), 64'd0);
    check("mid_rst_p", rsp_p, 64'd0);
    check("mid_rst_ready", 64'(req_ready), 64'd0);
    tick(2);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(req_ready), 64'h1);
    tick(2);
    check("post_rst_p", rsp_p, 64'hFFFF_FFFF_FFFF_FF70);
    check("post_rst_id", 64'(rsp_id), 64'd0);
    tick(2);
    check("post_rst2_p", rsp_p, 64'd25);
    check("post_rst2_id", 64'(rsp_id), 64'd2);
    tick(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mul32_share_ctrl.md
# mul32_share_ctrl

Sequencing controller that time-shares one `mul32bit` (32×32 signed → 64-bit combinational multiplier) among `N_REQ` requesters. It owns the multiplier's operand inputs and uses round-robin arbitration with a valid/ready handshake on each request port. It registers operands before the multiplier and the product after it, and returns each result with the winning requester's ID on a single valid/ready response port. It sits between the requesting datapath blocks and the shared `mul32bit` instance.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `ID_W`, `$clog2(N_REQ)`, width of requester ID
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  N_REQ  per-requester request valid
- `req_a`  in  N_REQ*32  packed signed multiplicands; requester i uses bits [32i+31:32i]
- `req_b`  in  N_REQ*32  packed signed multipliers, same packing as `req_a`
- `req_ready`  out  N_REQ  one-hot grant; accepted when `req_valid[i] & req_ready[i]`
- `rsp_valid`  out  1  result valid
- `rsp_ready`  in  1  consumer accepts result
- `rsp_id`  out  ID_W  requester index for the result
- `rsp_p`  out  64  signed product a*b

## Operation
- FSM states:
  - IDLE: accept a request if any is pending; go to CALC.
  - CALC: capture the product; go to DONE.
  - DONE: present the result until it is accepted.
- **Arbitration:** round-robin.
  - Pointer `rr_ptr` marks the highest-priority index.
  - The winner is the first `i` with `req_valid[i]=1`, searching `rr_ptr, rr_ptr+1, …` and wrapping modulo N_REQ.
  - On a grant to `i`, set `rr_ptr <= (i+1) mod N_REQ`.
  - `rr_ptr` does not move when there is no grant.
- **Grant:**
  - `req_ready` is combinational from state, `req_valid` and `rr_ptr`.
  - At most one bit is high, and only for a requester whose `req_valid` is high.
  - `req_ready` may be high only in IDLE, or in DONE in the same cycle that `rsp_ready=1`.
- **IDLE:** on a grant, latch `op_a`, `op_b` and `op_id`; go to CALC. Otherwise stay in IDLE.
- **CALC:** `op_a` and `op_b` drive the `mul32bit` instance. Latch `rsp_p <= p` and `rsp_id <= op_id`; go to DONE.
- **DONE:**
  - `rsp_valid=1`.
  - `rsp_p` and `rsp_id` hold stable until `rsp_ready=1`.
  - If `rsp_ready=1` and a request is granted in the same cycle, latch the new operands and go to CALC (back-to-back).
  - If `rsp_ready=1` with no request pending, go to IDLE.
  - If `rsp_ready=0`, stay in DONE with no grant.
- **Arithmetic:** full-precision two's-complement signed product, 64 bits, no truncation or saturation.
- A requester must hold `req_valid`, `req_a` and `req_b` until granted. The block never drops a granted request.
- **Reset** (async, any state, including mid-operation):
  - State returns to IDLE and any in-flight operation is discarded.
  - `rr_ptr=0`, `rsp_valid=0`, `rsp_p=0`, `rsp_id=0`, `op_a=op_b=0`.
  - `req_ready=0` while `rst` is high.

## Timing
- Grant in cycle T → `rsp_valid` high from cycle T+2.
- Sustained throughput: one result every 2 cycles, when `rsp_ready` is tied high and requests are always pending.
- Only the path `op_a/op_b → mul32bit → rsp_p` passes through the multiplier; it has one full cycle.
- `req_ready` depends combinationally on `req_valid` and `rsp_ready`. There is no combinational path from any input to `rsp_*`.
- Outputs after reset release: `rsp_valid=0` until the first grant plus 2 cycles.

## Structure
- Package `mul_share_pkg`:
  - constants `OP_W=32`, `PROD_W=64`
  - FSM state enum `{S_IDLE, S_CALC, S_DONE}`
- Sub-module `rr_arbiter`: combinational N-way round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, encoded index, any-grant.
- The existing `mul32bit` is instantiated unchanged (`.a(op_a), .b(op_b), .p(mul_p)`).

## Test plan
- **Single request:** requester 0 sends a=8, b=125 → `req_ready[0]` high that cycle; two cycles later `rsp_valid=1`, `rsp_id=0`, `rsp_p=1000`.
- **Signed values:**
  - a=-3, b=7 → `rsp_p=64'hFFFF_FFFF_FFFF_FFEB`.
  - a=32'h8000_0000, b=32'h8000_0000 → `rsp_p=64'h4000_0000_0000_0000`.
- **Round-robin fairness:** all 4 requesters valid continuously, `rsp_ready=1` → grant order 0,1,2,3,0; each `rsp_id` matches; one result every 2 cycles.
- **Backpressure:**
  - Setup: requester 2 sends 225×30 while `rsp_ready=0` for 5 cycles.
  - Hold: `rsp_p=6750` and `rsp_id=2` stay stable; no `req_ready` during the stall.
  - Release: when `rsp_ready` rises, the next pending request is granted in the same cycle.
- **Wrap-around:**
  - Setup: `rr_ptr=3`; requesters 1 and 3 valid.
  - First grant goes to 3 and `rr_ptr` becomes 0.
  - With requester 1 still valid, the next grant goes to 1.
- **Reset mid-operation:**
  - Assert `rst` in CALC → outputs are immediately `rsp_valid=0` and `rsp_p=0`, with `rr_ptr=0`.
  - After release, a fresh request from requester 0 completes normally with the correct product.
